pdm_playback_scheduler: RTL and testbench
=========================================

# pdm_playback_scheduler

Sequences 16-bit audio frames into the PDM serializer and shares it between two sample sources. Two valid/ready requesters are round-robin arbitrated into a small FIFO. A frame FSM loads one frame at a time into the serializer and waits for its completion. The block also drives the amplifier shutdown line with an idle timeout, and sits between the audio sources and the serializer in the audio output path.

## Interface
Parameters:
- DATA_W, 16, frame width; must match serializer data width
- FIFO_DEPTH, 4, frame FIFO entries; power of two, ≥2
- IDLE_TIMEOUT, 1024, consecutive IDLE cycles before amplifier shutdown; ≥1

Ports:
- clock_i  in  1  system clock, all logic on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  global playback enable
- req0_valid_i  in  1  source 0 frame valid
- req0_data_i  in  DATA_W  source 0 frame
- req0_ready_o  out  1  source 0 frame accepted this cycle when valid&ready
- req1_valid_i  in  1  source 1 frame valid
- req1_data_i  in  DATA_W  source 1 frame
- req1_ready_o  out  1  source 1 accept
- ser_enable_o  out  1  serializer enable, high for a whole frame
- ser_data_o  out  DATA_W  frame to serializer, registered, stable while ser_enable_o=1
- ser_done_i  in  1  serializer done, synchronous to clock_i, any pulse width
- sd_o  out  1  amplifier enable, 1 = on
- busy_o  out  1  FSM not in IDLE
- underrun_o  out  1  one-cycle pulse: frame finished with FIFO empty while enabled
- frames_o  out  16  completed-frame count, wraps 65535→0

## Operation
- Arbitration:
  - Round-robin. Priority pointer resets to source 0.
  - readyN_o = enable_i & !fifo_full & grantN. Grant is combinational from the valids and the pointer.
  - If both sources are valid, the pointer's source is granted. If only one is valid, that one is granted.
  - On every accepted transfer, the pointer moves to the other source.
  - At most one push per cycle. A ready held low stalls the source, so no frame is dropped.
- FIFO:
  - FIFO_DEPTH entries with wrap-around pointers.
  - Simultaneous push and pop is legal, including when full (pop frees the slot that cycle) and when empty with push (push first, pop next cycle; no bypass).
- ser_done_i is rising-edge detected through a registered previous value. Only the 0→1 transition counts as completion.
- FSM states:
  - IDLE: ser_enable_o=0. Go to LOAD if FIFO not empty and enable_i=1.
  - LOAD: pop FIFO head into ser_data_o. Go to RUN. Lasts exactly 1 cycle.
  - RUN: ser_enable_o=1. On done edge: frames_o += 1.
    - If FIFO not empty and enable_i=1, go to LOAD.
    - Otherwise go to IDLE. Pulse underrun_o if enable_i=1 and FIFO empty.
  - DRAIN: not a separate state. enable_i falling during RUN does not abort. The frame completes, then the FSM goes to IDLE and the FIFO contents are retained.
- Amplifier control:
  - Idle counter increments each IDLE cycle, saturating at IDLE_TIMEOUT, and clears in LOAD/RUN.
  - sd_o rises the cycle the FSM enters LOAD.
  - sd_o falls when the counter reaches IDLE_TIMEOUT.
- Reset (async, any state): FIFO flushed, pointer=source 0, FSM=IDLE, done-edge register=0.
- Output reset values: ser_enable_o=0, ser_data_o=0, sd_o=0, busy_o=0, underrun_o=0, frames_o=0, ready outputs 0.

## Timing
- Accept at edge t with FSM IDLE and FIFO empty:
  - FSM enters LOAD at edge t+1.
  - ser_enable_o=1 and ser_data_o=frame from edge t+2.
- Done edge detected at edge d (ser_done_i first sampled high):
  - frames_o increments at d.
  - ser_enable_o=0 from d (one LOAD cycle) when the FIFO is non-empty.
  - Next frame is enabled from d+1.
- Back-to-back frames therefore have a 1-cycle enable gap.
- underrun_o is high for exactly the cycle after d.
- sd_o falls IDLE_TIMEOUT cycles after IDLE entry, with no frames in between.
- ready outputs respond combinationally to the valids within the same cycle.

## Test plan
- Single frame: reset, enable_i=1, req0 sends 0xA5C3, done pulse 100 cycles later.
  - ser_data_o=0xA5C3 with ser_enable_o=1 from cycle 2.
  - frames_o=1 and underrun_o pulses once.
- Contention: both sources valid continuously, data 0x1111 (src0) and 0x2222 (src1).
  - Serializer sees 0x1111, 0x2222, 0x1111, 0x2222, …
  - No ready while the FIFO holds 4 frames.
- Full/simultaneous: FIFO full (4 frames), done edge while req1 valid.
  - Pop and push occur in the same cycle and count stays 4.
  - Frame order is preserved.
- Long done: ser_done_i held high 10 cycles.
  - Only one frame completes and frames_o increments by 1.
- Disable mid-frame: enable_i low during RUN with 2 frames queued.
  - Current frame finishes and the FSM goes to IDLE; FIFO count stays 2 and no underrun occurs.
  - After IDLE_TIMEOUT cycles sd_o=0.
  - Re-enable, then sd_o=1 at LOAD and the queued frames play in order.
- Async reset during RUN with 3 frames queued:
  - All outputs return to reset values immediately.
  - After release, no frame is emitted until a new push.

Source files
------------

// File: rtl/pdm_playback_scheduler.sv
`timescale 1ns/1ps
// pdm_playback_scheduler
// Round-robin merges two frame sources into a small FIFO and feeds one frame
// at a time to the PDM serializer. It also gates the amplifier (sd_o) with an
// idle timeout.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | serializer off; waits for a queued frame while enabled
// S_LOAD | one cycle: pops the FIFO head into the ser_data_o register
// S_RUN  | serializer on; waits for the rising edge of ser_done_i
module pdm_playback_scheduler #(
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              ser_enable_o,
  output logic [DATA_W-1:0] ser_data_o,
  input  logic              ser_done_i,
  output logic              sd_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic [15:0]       frames_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                prio_q;        // 0 = source 0 wins a tie
  logic                done_prev_q;
  logic [TW-1:0]       idle_cnt_q;    // down-counter, 0 = timed out
  logic                sd_q;
  logic                underrun_q;
  logic [15:0]         frames_q;
  logic [DATA_W-1:0]   ser_data_q;

  logic                grant0, grant1;
  logic                fifo_empty, fifo_full;
  logic                push, pop;
  logic [DATA_W-1:0]   push_data;
  logic                done_edge;
  logic                frame_done;

  // Pop is a registered decision (LOAD state), so letting it free a slot for
  // a same-cycle push creates no combinational loop back into ready.
  assign pop        = (state_q == S_LOAD);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH)) && !pop;
  assign done_edge  = ser_done_i && !done_prev_q;

  // Round-robin grant and ready; readies are held low while reset is asserted.
  always_comb begin
    grant0       = req0_valid_i && (!req1_valid_i || !prio_q);
    grant1       = req1_valid_i && (!req0_valid_i ||  prio_q);
    req0_ready_o = reset_n_i && enable_i && !fifo_full && grant0;
    req1_ready_o = reset_n_i && enable_i && !fifo_full && grant1;
    push         = req0_ready_o || req1_ready_o;
    push_data    = grant0 ? req0_data_i : req1_data_i;
  end

  // FIFO storage, no reset needed: occupancy is tracked by the pointers.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, occupancy and arbitration priority.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        prio_q   <= !grant1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && enable_i) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (done_edge) begin
          frame_done = 1'b1;
          if (!fifo_empty && enable_i) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, done-edge history, frame data, counters and underrun pulse.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      done_prev_q <= 1'b0;
      ser_data_q  <= '0;
      frames_q    <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= ser_done_i;
      underrun_q  <= frame_done && enable_i && fifo_empty;
      if (pop) begin
        ser_data_q <= mem_q[rd_ptr_q];
      end
      if (frame_done) begin
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  // Idle timer reloads while playing and counts IDLE cycles down to zero;
  // the amplifier turns on entering LOAD and off when the timer expires.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idle_cnt_q <= '0;
      sd_q       <= 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        idle_cnt_q <= TW'(IDLE_TIMEOUT);
      end else if (idle_cnt_q != '0) begin
        idle_cnt_q <= idle_cnt_q - TW'(1);
      end
      if (state_d == S_LOAD) begin
        sd_q <= 1'b1;
      end else if (state_q == S_IDLE && idle_cnt_q == TW'(1)) begin
        sd_q <= 1'b0;
      end
    end
  end

  assign ser_enable_o = (state_q == S_RUN);
  assign busy_o       = (state_q != S_IDLE);
  assign ser_data_o   = ser_data_q;
  assign sd_o         = sd_q;
  assign underrun_o   = underrun_q;
  assign frames_o     = frames_q;

endmodule

// File: tb/tb_pdm_playback_scheduler.sv
`timescale 1ns/1ps
// Directed bench for pdm_playback_scheduler: a vector table for arbitration
// and FIFO fill, then hand-written sequences for frame timing corner cases.
module tb_pdm_playback_scheduler;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          done = 1'b0;
  logic          r0, r1, sen, sd, busy, underrun;
  logic [DW-1:0] sdata;
  logic [15:0]   frames;

  int n_checks = 0;
  int n_fail   = 0;

  pdm_playback_scheduler #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TIMEOUT)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
    .ser_enable_o(sen), .ser_data_o(sdata), .ser_done_i(done),
    .sd_o(sd), .busy_o(busy), .underrun_o(underrun), .frames_o(frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, v0, v1;
    logic [DW-1:0] d0, d1;
    logic          clk_after;
    logic          r0, r1, sen, busy;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en    v0    v1    d0        d1        clk   r0    r1    sen   busy
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0AAA, 16'h0BBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 16'h0BBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0AAA, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h3333, 16'h0BBB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h0AAA, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 16'h0BBB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'h0AAA, 16'h0BBB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0AAA, 16'h0BBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values, with enable and a valid asserted to show ready is held off.
    en = 1'b1; v0 = 1'b1;
    #2;
    check("rst_ready0", r0, 0);
    check("rst_ser_enable", sen, 0);
    check("rst_ser_data", sdata, 0);
    check("rst_sd", sd, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frames", frames, 0);
    en = 1'b0; v0 = 1'b0;
    do_reset();

    // Single frame: accept, LOAD, RUN, done after ~100 cycles, idle timeout.
    en = 1'b1; v0 = 1'b1; d0 = 16'hA5C3;
    #1;
    check("single_ready0", r0, 1);
    tick();
    v0 = 1'b0;
    check("single_idle_after_accept", busy, 0);
    tick();
    check("single_load_busy", busy, 1);
    check("single_load_ser_enable", sen, 0);
    check("single_load_sd", sd, 1);
    tick();
    check("single_run_ser_enable", sen, 1);
    check("single_run_ser_data", sdata, 16'hA5C3);
    repeat (98) tick();
    check("single_still_running", sen, 1);
    done_pulse();
    check("single_frames", frames, 1);
    check("single_done_ser_enable", sen, 0);
    check("single_underrun_pulse", underrun, 1);
    tick();
    check("single_underrun_cleared", underrun, 0);
    repeat (TIMEOUT - 2) tick();
    check("single_sd_before_timeout", sd, 1);
    tick();
    check("single_sd_after_timeout", sd, 0);

    // Arbitration and FIFO fill table.
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      en = vecs[i].en; v0 = vecs[i].v0; v1 = vecs[i].v1;
      d0 = vecs[i].d0; d1 = vecs[i].d1;
      #1;
      check($sformatf("vec%0d_ready0", i), r0, vecs[i].r0);
      check($sformatf("vec%0d_ready1", i), r1, vecs[i].r1);
      check($sformatf("vec%0d_ser_enable", i), sen, vecs[i].sen);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      if (vecs[i].clk_after) tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    check("table_first_frame", sdata, 16'h1111);

    // Full FIFO: done while src1 waits; pop and push share the LOAD cycle.
    v1 = 1'b1; d1 = 16'h6666;
    #1;
    check("full_ready1_blocked", r1, 0);
    done_pulse();
    check("full_frames", frames, 1);
    check("full_load_ready1", r1, 1);
    tick();
    v1 = 1'b0;
    check("full_next_data", sdata, 16'h2222);
    check("full_next_enable", sen, 1);
    v1 = 1'b1;
    #1;
    check("full_still_full", r1, 0);
    v1 = 1'b0;
    done_pulse();
    tick();
    check("order_3", sdata, 16'h3333);

    // Long done: held high 10 cycles completes exactly one frame.
    done = 1'b1;
    tick();
    check("long_frames_edge", frames, 3);
    tick();
    check("long_next_data", sdata, 16'h4444);
    repeat (8) tick();
    done = 1'b0;
    tick();
    check("long_frames_once", frames, 3);
    check("long_still_running", sen, 1);
    done_pulse();
    tick();
    check("order_5", sdata, 16'h5555);
    done_pulse();
    tick();
    check("order_6", sdata, 16'h6666);
    done_pulse();
    check("drain_frames", frames, 6);
    check("drain_busy", busy, 0);
    check("drain_underrun", underrun, 1);

    // Disable during RUN with two frames queued.
    en = 1'b0;
    do_reset();
    en = 1'b1; v0 = 1'b1;
    d0 = 16'h0C01; tick();
    d0 = 16'h0C02; tick();
    d0 = 16'h0C03; tick();
    v0 = 1'b0;
    check("dis_first_data", sdata, 16'h0C01);
    repeat (5) tick();
    en = 1'b0;
    tick();
    check("dis_keeps_running", sen, 1);
    done_pulse();
    check("dis_frames", frames, 1);
    check("dis_idle", busy, 0);
    tick();
    check("dis_no_underrun", underrun, 0);
    repeat (TIMEOUT - 2) tick();
    check("dis_sd_before_timeout", sd, 1);
    tick();
    check("dis_sd_off", sd, 0);
    check("dis_stays_idle", busy, 0);
    en = 1'b1;
    tick();
    check("reen_load_sd", sd, 1);
    check("reen_load_busy", busy, 1);
    tick();
    check("reen_data_2", sdata, 16'h0C02);
    done_pulse();
    tick();
    check("reen_data_3", sdata, 16'h0C03);
    done_pulse();
    check("reen_frames", frames, 3);
    check("reen_underrun", underrun, 1);

    // Async reset in RUN with three frames queued.
    en = 1'b0;
    do_reset();
    en = 1'b1; v0 = 1'b1;
    d0 = 16'h0D01; tick();
    d0 = 16'h0D02; tick();
    d0 = 16'h0D03; tick();
    d0 = 16'h0D04; tick();
    d0 = 16'h0D05;
    check("ar_running_data", sdata, 16'h0D01);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ser_enable", sen, 0);
    check("ar_ser_data", sdata, 0);
    check("ar_busy", busy, 0);
    check("ar_sd", sd, 0);
    check("ar_ready0", r0, 0);
    v0 = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("ar_idle_%0d", k), busy | sen, 0);
    end
    v0 = 1'b1; d0 = 16'h0E01;
    tick();
    v0 = 1'b0;
    tick();
    tick();
    check("ar_new_enable", sen, 1);
    check("ar_new_data", sdata, 16'h0E01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
